// File: rtl/clip_refresh_sched_if.sv
// clip_refresh_sched_if: groups the refresh scheduler's frame, object-memory
// and clipper handshake signals. The master modport is the scheduler side and
// the slave modport is the surrounding pipeline (or testbench).
interface clip_refresh_sched_if;
  logic        frame_tick;
  logic [31:0] obj_map;
  logic        changed;
  logic        writing;
  logic        end_of_obj;
  logic [4:0]  addr;
  logic        read_en;
  logic        reading;
  logic        start_refresh;
  logic [3:0]  cycle;
  logic        obj_vld;
  logic        clr_changed;
  logic        frame_done;
  logic        timeout;
  logic [7:0]  ovr_cnt;

  modport master (
    input  frame_tick, obj_map, changed, writing, end_of_obj,
    output addr, read_en, reading, start_refresh, cycle, obj_vld,
           clr_changed, frame_done, timeout, ovr_cnt
  );

  modport slave (
    output frame_tick, obj_map, changed, writing, end_of_obj,
    input  addr, read_en, reading, start_refresh, cycle, obj_vld,
           clr_changed, frame_done, timeout, ovr_cnt
  );
endinterface

// File: rtl/clip_refresh_sched.sv
// clip_refresh_sched: frame-level refresh scheduler for the clipping pipeline.
// On a frame tick with the object table changed it waits for the matrix unit to
// release object memory, snapshots the object map, fetches every valid object
// in ascending slot order with a four-phase one-hot strobe, waits for the
// clipper to drain and then releases the table. Ticks that arrive while busy
// are counted in a saturating overrun counter.
// Optional drain watchdog: define CLIP_SCHED_WDOG_EN to enable it.
module clip_refresh_sched #(
  parameter int NUM_OBJ = 32,
  parameter int WDOG_W  = 20
) (
  input logic                  clk,
  input logic                  rst_n,
  clip_refresh_sched_if.master bus
);
  localparam int ADDR_W = 5;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_START     = 3'd2,
    S_SCAN      = 3'd3,
    S_FETCH     = 3'd4,
    S_DRAIN     = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  if (WDOG_W < 2) begin : g_param_check
    $error("clip_refresh_sched: WDOG_W must be at least 2");
  end

  state_t              state_r, state_n;
  logic [NUM_OBJ-1:0]  snap_r, snap_n;
  logic [ADDR_W-1:0]   idx_r, idx_n, low_idx_s;
  logic [1:0]          phase_r, phase_n;
  logic                any_r, any_n;

  logic [ADDR_W-1:0]   addr_r;
  logic                read_en_r, reading_r, start_r, obj_vld_r;
  logic [3:0]          cycle_r;
  logic                clr_r, done_r, timeout_r;
  logic [7:0]          ovr_r;

`ifdef CLIP_SCHED_WDOG_EN
  logic [WDOG_W-1:0]   wdog_cnt_r;
  logic                wdog_fire_s;
`endif

  // Lowest set slot of the remaining snapshot (priority encoder, slot 0 wins).
  function automatic logic [ADDR_W-1:0] lowest_set(input logic [NUM_OBJ-1:0] v);
    logic [ADDR_W-1:0] r;
    r = {ADDR_W{1'b0}};
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = i[ADDR_W-1:0];
      end
    end
    return r;
  endfunction

  assign low_idx_s = lowest_set(snap_r);

  // Next-state and next-datapath decode for the refresh sequence.
  always_comb begin
    state_n = state_r;
    snap_n  = snap_r;
    idx_n   = idx_r;
    phase_n = phase_r;
    any_n   = any_r;
`ifdef CLIP_SCHED_WDOG_EN
    wdog_fire_s = 1'b0;
`endif
    case (state_r)
      S_IDLE: begin
        if (bus.frame_tick && bus.changed) begin
          state_n = bus.writing ? S_WAIT_LOCK : S_START;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WAIT_LOCK: begin
        if (!bus.writing) begin
          state_n = S_START;
        end else begin
          state_n = S_WAIT_LOCK;
        end
      end
      S_START: begin
        snap_n  = bus.obj_map;
        any_n   = 1'b0;
        state_n = S_SCAN;
      end
      S_SCAN: begin
        if (snap_r == {NUM_OBJ{1'b0}}) begin
          state_n = any_r ? S_DRAIN : S_DONE;
        end else begin
          idx_n   = low_idx_s;
          phase_n = 2'd0;
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        if (phase_r == 2'd3) begin
          snap_n[idx_r] = 1'b0;
          any_n         = 1'b1;
          phase_n       = 2'd0;
          state_n       = S_SCAN;
        end else begin
          phase_n = phase_r + 2'd1;
        end
      end
      S_DRAIN: begin
        if (bus.end_of_obj) begin
          state_n = S_DONE;
        end else begin
`ifdef CLIP_SCHED_WDOG_EN
          // The counter reaches all-ones on the same edge DONE is entered.
          if (wdog_cnt_r == {{(WDOG_W-1){1'b1}}, 1'b0}) begin
            wdog_fire_s = 1'b1;
            state_n     = S_DONE;
          end else begin
            state_n = S_DRAIN;
          end
`else
          state_n = S_DRAIN;
`endif
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, snapshot and fetch-walk registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      snap_r  <= {NUM_OBJ{1'b0}};
      idx_r   <= {ADDR_W{1'b0}};
      phase_r <= 2'd0;
      any_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      snap_r  <= snap_n;
      idx_r   <= idx_n;
      phase_r <= phase_n;
      any_r   <= any_n;
    end
  end

  // Outputs are flopped from the next-state decode so they align with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r    <= {ADDR_W{1'b0}};
      read_en_r <= 1'b0;
      obj_vld_r <= 1'b0;
      cycle_r   <= 4'b0000;
      reading_r <= 1'b0;
      start_r   <= 1'b0;
      clr_r     <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      addr_r    <= (state_n == S_FETCH) ? idx_n : {ADDR_W{1'b0}};
      read_en_r <= (state_n == S_FETCH) && (phase_n == 2'd0);
      obj_vld_r <= (state_n == S_FETCH) && (phase_n != 2'd0);
      cycle_r   <= (state_n == S_FETCH) ? (4'b0001 << phase_n) : 4'b0000;
      reading_r <= (state_n != S_IDLE) && (state_n != S_WAIT_LOCK);
      start_r   <= (state_n == S_START);
      clr_r     <= (state_n == S_DONE);
      done_r    <= (state_n == S_DONE);
    end
  end

  // Saturating count of frame ticks that arrive while a refresh is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_r <= 8'd0;
    end else if (bus.frame_tick && (state_r != S_IDLE) && (ovr_r != 8'hFF)) begin
      ovr_r <= ovr_r + 8'd1;
    end else begin
      ovr_r <= ovr_r;
    end
  end

`ifdef CLIP_SCHED_WDOG_EN
  // Drain watchdog: restarts on DRAIN entry, counts while draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
    end else if ((state_n == S_DRAIN) && (state_r != S_DRAIN)) begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
    end else if (state_r == S_DRAIN) begin
      wdog_cnt_r <= wdog_cnt_r + {{(WDOG_W-1){1'b0}}, 1'b1};
    end else begin
      wdog_cnt_r <= wdog_cnt_r;
    end
  end

  // Sticky timeout flag; a new refresh start clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_r <= 1'b0;
    end else if (state_n == S_START) begin
      timeout_r <= 1'b0;
    end else if (wdog_fire_s) begin
      timeout_r <= 1'b1;
    end else begin
      timeout_r <= timeout_r;
    end
  end
`else
  // No watchdog in this build: timeout never asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
    end
  end
`endif

  assign bus.addr          = addr_r;
  assign bus.read_en       = read_en_r;
  assign bus.reading       = reading_r;
  assign bus.start_refresh = start_r;
  assign bus.cycle         = cycle_r;
  assign bus.obj_vld       = obj_vld_r;
  assign bus.clr_changed   = clr_r;
  assign bus.frame_done    = done_r;
  assign bus.timeout       = timeout_r;
  assign bus.ovr_cnt       = ovr_r;
endmodule

// File: tb/tb_clip_refresh_sched.sv
// tb_clip_refresh_sched: directed stimulus for the refresh scheduler with a
// timeline model (refresh start time, per-object 5-cycle slots, drain and
// done) checked against the DUT every cycle, plus literal timing checks.
module tb_clip_refresh_sched;
  localparam int TB_WDOG_W = 4;
  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;
  localparam int M_DONE  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clip_refresh_sched_if bus_if ();

  clip_refresh_sched #(.NUM_OBJ(32), .WDOG_W(TB_WDOG_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // timeline model state
  int m_mode = M_IDLE;
  int m_rel  = 0;
  int m_dcnt = 0;
  int m_ovr  = 0;
  bit m_to   = 1'b0;
  int m_q[$];

  // observed events
  int rd_cyc[$];
  int rd_addr[$];
  int last_done  = -1;
  int last_start = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [23:0] expect_vec();
    logic [4:0] a   = 5'd0;
    logic [3:0] cy  = 4'd0;
    logic       rd  = 1'b0;
    logic       rdg = 1'b0;
    logic       st  = 1'b0;
    logic       vld = 1'b0;
    logic       clr = 1'b0;
    logic       fd  = 1'b0;
    int r;
    int p;
    case (m_mode)
      M_RUN: begin
        rdg = 1'b1;
        if (m_rel == 0) begin
          st = 1'b1;
        end else begin
          r = m_rel - 1;
          p = r % 5;
          if (p != 0 && (r / 5) < m_q.size()) begin
            a   = 5'(m_q[r / 5]);
            cy  = 4'b0001 << (p - 1);
            rd  = (p == 1);
            vld = (p > 1);
          end
        end
      end
      M_DRAIN: rdg = 1'b1;
      M_DONE: begin
        rdg = 1'b1;
        fd  = 1'b1;
        clr = 1'b1;
      end
      default: ;
    endcase
    return {a, rd, rdg, st, cy, vld, clr, fd, m_to, 8'(m_ovr)};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {bus_if.addr, bus_if.read_en, bus_if.reading, bus_if.start_refresh,
            bus_if.cycle, bus_if.obj_vld, bus_if.clr_changed, bus_if.frame_done,
            bus_if.timeout, bus_if.ovr_cnt};
  endfunction

  // Model: advances the refresh timeline on every rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_mode = M_IDLE; m_rel = 0; m_dcnt = 0; m_ovr = 0; m_to = 1'b0;
      m_q.delete();
    end else begin
      if (bus_if.frame_tick && m_mode != M_IDLE && m_ovr < 255) m_ovr++;
      case (m_mode)
        M_IDLE: if (bus_if.frame_tick && bus_if.changed) begin
          if (bus_if.writing) m_mode = M_WAIT;
          else begin m_mode = M_RUN; m_rel = 0; m_to = 1'b0; end
        end
        M_WAIT: if (!bus_if.writing) begin
          m_mode = M_RUN; m_rel = 0; m_to = 1'b0;
        end
        M_RUN: begin
          m_rel++;
          if (m_rel == 1) begin
            m_q.delete();
            for (int i = 0; i < 32; i++) if (bus_if.obj_map[i]) m_q.push_back(i);
          end
          if (m_rel == 5 * m_q.size() + 2) begin
            m_mode = (m_q.size() == 0) ? M_DONE : M_DRAIN;
            m_dcnt = 0;
          end
        end
        M_DRAIN: if (bus_if.end_of_obj) m_mode = M_DONE;
        else begin
          m_dcnt++;
`ifdef CLIP_SCHED_WDOG_EN
          if (m_dcnt == (1 << TB_WDOG_W) - 1) begin m_mode = M_DONE; m_to = 1'b1; end
`endif
        end
        M_DONE: m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // Compare: every cycle, just after the edge, plus event logging.
  initial forever begin
    @(posedge clk);
    #1;
    check("outputs", {8'h00, dut_vec()}, {8'h00, expect_vec()});
    if (bus_if.read_en) begin
      rd_cyc.push_back(cyc);
      rd_addr.push_back(int'(bus_if.addr));
    end
    if (bus_if.frame_done) last_done = cyc;
    if (bus_if.start_refresh) last_start = cyc;
  end

  initial begin
    #400000;
    $display("FAIL sim_time_limit cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "time limit");
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic tick(output int t);
    bus_if.frame_tick = 1'b1;
    t = cyc;
    @(negedge clk);
    bus_if.frame_tick = 1'b0;
  endtask

  task automatic finish_refresh();
    int n = 0;
    while (m_mode != M_IDLE && n < 400) begin
      bus_if.end_of_obj = (m_mode == M_DRAIN);
      @(negedge clk);
      n++;
    end
    bus_if.end_of_obj = 1'b0;
    check("refresh_ends", 32'(bus_if.reading), 32'd0);
  endtask

  initial begin
    int t, w, d0;
    bus_if.frame_tick = 1'b0;
    bus_if.obj_map    = 32'h0;
    bus_if.changed    = 1'b0;
    bus_if.writing    = 1'b0;
    bus_if.end_of_obj = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_reading", 32'(bus_if.reading), 32'd0);
    check("reset_ovr", 32'(bus_if.ovr_cnt), 32'd0);

    // tick with nothing changed: stays idle, no overrun
    tick(t);
    repeat (3) @(negedge clk);
    check("idle_tick_ovr", 32'(bus_if.ovr_cnt), 32'd0);
    check("idle_tick_no_start", 32'(last_start), 32'hFFFF_FFFF);

    // three objects: slots 0, 2, 31
    bus_if.obj_map = 32'h8000_0005;
    bus_if.changed = 1'b1;
    rd_cyc.delete(); rd_addr.delete();
    tick(t);
    wait_until(t + 5);
    bus_if.obj_map = 32'hFFFF_FFFF;          // must be ignored
    wait_until(t + 10);
    bus_if.end_of_obj = 1'b1;                // ignored outside DRAIN
    @(negedge clk);
    bus_if.end_of_obj = 1'b0;
    wait_until(t + 30);
    bus_if.end_of_obj = 1'b1;
    @(negedge clk);
    bus_if.end_of_obj = 1'b0;
    check("fetch_count", 32'(rd_cyc.size()), 32'd3);
    check("read_en_1", 32'((rd_cyc.size() > 0) ? rd_cyc[0] : -1), 32'(t + 3));
    check("read_en_2", 32'((rd_cyc.size() > 1) ? rd_cyc[1] : -1), 32'(t + 8));
    check("read_en_3", 32'((rd_cyc.size() > 2) ? rd_cyc[2] : -1), 32'(t + 13));
    check("addr_1", 32'((rd_addr.size() > 0) ? rd_addr[0] : -1), 32'd0);
    check("addr_2", 32'((rd_addr.size() > 1) ? rd_addr[1] : -1), 32'd2);
    check("addr_3", 32'((rd_addr.size() > 2) ? rd_addr[2] : -1), 32'd31);
    check("done_cycle", 32'(last_done), 32'(t + 31));
    bus_if.changed = 1'b0;
    bus_if.obj_map = 32'h0;
    @(negedge clk);

    // writing held 6 cycles across the tick
    bus_if.obj_map = 32'h0000_0010;
    bus_if.changed = 1'b1;
    bus_if.writing = 1'b1;
    w = cyc;
    wait_until(w + 2);
    tick(t);
    wait_until(w + 6);
    bus_if.writing = 1'b0;
    wait_until(w + 8);
    check("lock_start", 32'(last_start), 32'(w + 7));
    finish_refresh();
    bus_if.changed = 1'b0;
    @(negedge clk);

    // empty map
    bus_if.obj_map = 32'h0;
    bus_if.changed = 1'b1;
    rd_cyc.delete(); rd_addr.delete();
    tick(t);
    wait_until(t + 4);
    check("empty_start", 32'(last_start), 32'(t + 1));
    check("empty_done", 32'(last_done), 32'(t + 3));
    check("empty_no_read", 32'(rd_cyc.size()), 32'd0);

    // reset mid-refresh aborts without frame_done
    bus_if.obj_map = 32'h0000_0300;
    d0 = last_done;
    tick(t);
    wait_until(t + 6);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_until(t + 12);
    check("abort_no_done", 32'(last_done), 32'(d0));
    check("abort_reading", 32'(bus_if.reading), 32'd0);

    // overrun accounting
    bus_if.obj_map = 32'h0000_0001;
    bus_if.changed = 1'b1;
    tick(t);
    wait_until(t + 3); tick(w);
    wait_until(t + 6); tick(w);
    wait_until(t + 9); tick(w);
    finish_refresh();
    check("ovr_three", 32'(bus_if.ovr_cnt), 32'd3);
    bus_if.frame_tick = 1'b1;
    repeat (320) @(negedge clk);
    bus_if.frame_tick = 1'b0;
    finish_refresh();
    check("ovr_saturate", 32'(bus_if.ovr_cnt), 32'd255);

    // drain watchdog (or lack of one)
    bus_if.obj_map = 32'h0000_0004;
    d0 = last_done;
    tick(t);
`ifdef CLIP_SCHED_WDOG_EN
    wait_until(t + 8 + 16);
    check("wdog_done", 32'(last_done), 32'(t + 8 + 15));
    check("wdog_timeout", 32'(bus_if.timeout), 32'd1);
    tick(w);
    wait_until(w + 2);
    check("timeout_cleared", 32'(bus_if.timeout), 32'd0);
    finish_refresh();
`else
    wait_until(t + 8 + 40);
    check("no_wdog_no_done", 32'(last_done), 32'(d0));
    check("no_wdog_reading", 32'(bus_if.reading), 32'd1);
    check("no_wdog_timeout", 32'(bus_if.timeout), 32'd0);
    finish_refresh();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clip_refresh_sched.md
# clip_refresh_sched

Frame-level refresh scheduler for the clipping pipeline. Arms once per frame tick while the object table is marked changed. Waits out any matrix-unit write, snapshots the 32-bit object map and walks the set bits with a priority encoder. For each valid object it drives the object-memory read and a one-hot four-phase fetch strobe into the line handler, then waits for the clipper to drain before releasing the table. It replaces free-running refresh timing with an explicit, observable sequence and adds overrun accounting and an optional drain watchdog.

## Interface
- NUM_OBJ, 32: object slots; fixed, sets addr width 5.
- WDOG_W, 20: watchdog counter width; drain timeout = 2^WDOG_W − 1 cycles.

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle frame-start pulse
- obj_map  in  32  valid bit per object slot
- changed  in  1  object table modified since last refresh
- writing  in  1  matrix unit is writing object memory
- end_of_obj  in  1  clipper has emitted every line of the frame
- addr  out  5  object memory read address
- read_en  out  1  object memory read strobe
- reading  out  1  scheduler owns object memory; matrix unit must not write
- start_refresh  out  1  one-cycle pulse; clears clipper FIFOs and counters
- cycle  out  4  one-hot fetch phase: bit0 = phase 1 … bit3 = phase 4
- obj_vld  out  1  object word on obj bus valid
- clr_changed  out  1  one-cycle pulse; clears the changed flag
- frame_done  out  1  one-cycle pulse at end of refresh
- timeout  out  1  sticky; drain watchdog fired (watchdog builds only)
- ovr_cnt  out  8  saturating count of dropped frame ticks

## Operation
- Moore FSM with states IDLE, WAIT_LOCK, START, SCAN, FETCH, DRAIN, DONE.
- **IDLE**
  - frame_tick && changed && writing → WAIT_LOCK.
  - frame_tick && changed && !writing → START.
  - frame_tick && !changed → stay in IDLE; not counted as an overrun.
- **WAIT_LOCK**: → START on the first cycle with writing = 0.
- **START**
  - start_refresh = 1.
  - snap ← obj_map; any_fetched ← 0.
  - → SCAN.
- **SCAN**
  - idx ← lowest set bit of snap.
  - snap == 0 → DRAIN if any_fetched, else DONE.
  - Otherwise → FETCH with phase counter = 1.
- **FETCH**: four cycles, phase p = 1..4, cycle = 1 << (p−1).
  - addr = idx throughout.
  - read_en = 1 in p1.
  - obj_vld = 1 in p2..p4.
  - In p4: clear snap[idx], set any_fetched, → SCAN.
- **DRAIN**: → DONE on end_of_obj.
- **DONE**: frame_done = 1, clr_changed = 1, → IDLE.
- reading = 1 in every state except IDLE and WAIT_LOCK.
- frame_tick in any state other than IDLE: tick is dropped; ovr_cnt increments, saturating at 255.
- obj_map changes after START are ignored until the next refresh.
- end_of_obj outside DRAIN is ignored.

## Timing
- Reset value of every output is 0; FSM resets to IDLE; snap = 0.
- Reset mid-refresh aborts immediately. No frame_done or clr_changed is issued, so changed stays set.
- All outputs are registered, or decoded from registered state only. No input-to-output combinational path.
- frame_tick sampled at edge T with writing = 0:
  - START (start_refresh) during cycle T+1.
  - SCAN at T+2.
  - First p1 at T+3.
- Per object cost: 5 cycles (1 SCAN + 4 FETCH).
- With k valid objects, DRAIN is entered at T+3+5k.
- DONE follows end_of_obj by one cycle.
- Empty map: START → SCAN → DONE, so frame_done fires at T+3.
- writing asserted in the same cycle as frame_tick takes precedence: WAIT_LOCK is entered; START follows the first cycle writing is low.
- The tick sampled in the DONE cycle counts as an overrun.

## Configuration
- CLIP_SCHED_WDOG_EN defined:
  - A WDOG_W-bit counter clears on DRAIN entry and increments each cycle in DRAIN.
  - At all-ones it forces → DONE (frame_done and clr_changed pulse) and sets timeout.
  - timeout clears only on reset or on the next start_refresh.
- CLIP_SCHED_WDOG_EN undefined:
  - No counter; DRAIN waits indefinitely for end_of_obj.
  - timeout is tied to 0.

## Test plan
- Reset then idle: all outputs 0. A frame_tick with changed = 0 leaves the FSM in IDLE and ovr_cnt at 0.
- obj_map = 32'h8000_0005, changed = 1:
  - Fetches addr 0, 2, 31 in order; read_en pulses at T+3, T+8, T+13.
  - cycle walks 1, 2, 4, 8 per object.
  - end_of_obj at T+30 → frame_done and clr_changed at T+31.
- writing held 6 cycles across frame_tick: reading stays 0 and start_refresh is delayed until the first cycle after writing falls.
- obj_map = 0: start_refresh at T+1, frame_done at T+3, no read_en.
- Three frame_ticks during an active refresh → ovr_cnt = 3. Forcing 300 extra overruns → ovr_cnt holds 255.
- Watchdog build, WDOG_W = 4, end_of_obj never asserted:
  - DONE is entered 15 cycles after DRAIN entry and timeout = 1.
  - The next start_refresh clears timeout.
  - In a non-watchdog build the same stimulus stays in DRAIN.
